fp32_align_ctrl: RTL and testbench



---
 rtl/fp32_pkg.sv | 34 +++
 rtl/fp32_align_ctrl_if.sv | 30 +++
 rtl/fp32_exp_compare.sv | 44 ++++
 rtl/fp32_align_ctrl.sv | 168 ++++++++++++++++
 tb/tb_fp32_align_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp32_pkg.sv
// Shared FP32 definitions for the add/sub front end: field widths, constants,
// the operand struct, alignment FSM states and operand classification helpers.
package fp32_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 24;

  localparam logic [EXP_W-1:0] EXP_BIAS = 8'd127;
  localparam logic [EXP_W-1:0] EXP_ONES = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMP   = 2'd1,
    ALIGN = 2'd2,
    HOLD  = 2'd3
  } align_state_e;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  // Zero/subnormal operands sit at effective exponent 1 with no hidden bit.
  function automatic logic [EXP_W-1:0] eff_exp(input fp32_t x);
    return (x.exp == 8'd0) ? 8'd1 : x.exp;
  endfunction

  function automatic logic [MANT_W-1:0] full_mant(input fp32_t x);
    return {(x.exp != 8'd0), x.frac};
  endfunction

endpackage

// File: rtl/fp32_align_ctrl_if.sv
// Operand and aligned-result handshakes of the FP32 alignment sequencer.
interface fp32_align_ctrl_if;

  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_op_a;
  logic [31:0] i_op_b;
  logic        i_sub;
  logic        o_valid;
  logic        i_ready;
  logic [7:0]  o_exp;
  logic [23:0] o_big_mant;
  logic [23:0] o_small_mant;
  logic        o_sign;
  logic        o_eff_sub;
  logic        o_sticky;

  modport master (
    output i_valid, i_op_a, i_op_b, i_sub, i_ready,
    input  o_ready, o_valid, o_exp, o_big_mant, o_small_mant,
           o_sign, o_eff_sub, o_sticky
  );

  modport slave (
    input  i_valid, i_op_a, i_op_b, i_sub, i_ready,
    output o_ready, o_valid, o_exp, o_big_mant, o_small_mant,
           o_sign, o_eff_sub, o_sticky
  );

endinterface

// File: rtl/fp32_exp_compare.sv
// Combinational classification and magnitude ordering of two FP32 operands.
module fp32_exp_compare
  import fp32_pkg::*;
(
  input  fp32_t             a,
  input  fp32_t             b,
  output logic              swap,
  output logic [EXP_W-1:0]  diff,
  output logic [EXP_W-1:0]  big_exp,
  output logic [EXP_W-1:0]  small_exp,
  output logic [MANT_W-1:0] big_mant,
  output logic [MANT_W-1:0] small_mant
);

  logic [EXP_W-1:0]  exp_a_s;
  logic [EXP_W-1:0]  exp_b_s;
  logic [MANT_W-1:0] mant_a_s;
  logic [MANT_W-1:0] mant_b_s;

  assign exp_a_s  = eff_exp(a);
  assign exp_b_s  = eff_exp(b);
  assign mant_a_s = full_mant(a);
  assign mant_b_s = full_mant(b);

  // Order by {exponent, mantissa}; ties keep A as the big operand.
  always_comb begin
    swap       = 1'b0;
    big_exp    = exp_a_s;
    small_exp  = exp_b_s;
    big_mant   = mant_a_s;
    small_mant = mant_b_s;
    if ({exp_b_s, mant_b_s} > {exp_a_s, mant_a_s}) begin
      swap       = 1'b1;
      big_exp    = exp_b_s;
      small_exp  = exp_a_s;
      big_mant   = mant_b_s;
      small_mant = mant_a_s;
    end else begin
      swap       = 1'b0;
    end
    diff = big_exp - small_exp;
  end

endmodule

// File: rtl/fp32_align_ctrl.sv
// Four-state FP32 add/sub alignment sequencer (IDLE, CMP, ALIGN, HOLD).
// Define FP32_ALIGN_STICKY_EN to build the sticky-bit logic behind o_sticky.
module fp32_align_ctrl
  import fp32_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  fp32_align_ctrl_if.slave   bus
);

  align_state_e      state_r, state_s;
  fp32_t             op_a_r, op_b_r;
  logic              sub_r;

  logic              swap_s;
  logic [EXP_W-1:0]  diff_s, big_exp_s, small_exp_s;
  logic [MANT_W-1:0] big_mant_s, small_mant_s;

  logic [EXP_W-1:0]  cmp_exp_r, diff_r;
  logic [MANT_W-1:0] cmp_big_r, cmp_small_r;
  logic              cmp_sign_r, cmp_eff_sub_r;

  logic [MANT_W-1:0] shifted_s;
  logic [EXP_W-1:0]  exp_r;
  logic [MANT_W-1:0] big_r, small_r;
  logic              sign_r, eff_sub_r, valid_r, ready_r;

  fp32_exp_compare u_cmp (
    .a          (op_a_r),
    .b          (op_b_r),
    .swap       (swap_s),
    .diff       (diff_s),
    .big_exp    (big_exp_s),
    .small_exp  (small_exp_s),
    .big_mant   (big_mant_s),
    .small_mant (small_mant_s)
  );

  // Next-state logic; operands are only looked at in IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (bus.i_valid) state_s = CMP;  else state_s = IDLE;
      CMP:     state_s = ALIGN;
      ALIGN:   state_s = HOLD;
      HOLD:    if (bus.i_ready) state_s = IDLE; else state_s = HOLD;
      default: state_s = IDLE;
    endcase
  end

  // State register with handshake flags registered from the next state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
      ready_r <= 1'b1;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_s;
      ready_r <= (state_s == IDLE);
      valid_r <= (state_s == HOLD);
    end
  end

  // Operand capture on acceptance.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_a_r <= '0;
      op_b_r <= '0;
      sub_r  <= 1'b0;
    end else if (state_r == IDLE && bus.i_valid) begin
      op_a_r <= bus.i_op_a;
      op_b_r <= bus.i_op_b;
      sub_r  <= bus.i_sub;
    end else begin
      sub_r  <= sub_r;
    end
  end

  // Compare-stage register: ordering, exponent difference and sign flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cmp_exp_r     <= '0;
      diff_r        <= '0;
      cmp_big_r     <= '0;
      cmp_small_r   <= '0;
      cmp_sign_r    <= 1'b0;
      cmp_eff_sub_r <= 1'b0;
    end else if (state_r == CMP) begin
      cmp_exp_r     <= big_exp_s;
      diff_r        <= diff_s;
      cmp_big_r     <= big_mant_s;
      cmp_small_r   <= small_mant_s;
      cmp_sign_r    <= swap_s ? (op_b_r.sign ^ sub_r) : op_a_r.sign;
      cmp_eff_sub_r <= op_a_r.sign ^ op_b_r.sign ^ sub_r;
    end else begin
      cmp_eff_sub_r <= cmp_eff_sub_r;
    end
  end

  // Right-shift alignment; any shift of 24 or more empties the mantissa.
  always_comb begin
    shifted_s = '0;
    if (diff_r >= 8'd24) begin
      shifted_s = 24'd0;
    end else begin
      shifted_s = cmp_small_r >> diff_r[4:0];
    end
  end

  // Result registers, loaded in ALIGN and held through HOLD.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      exp_r     <= '0;
      big_r     <= '0;
      small_r   <= '0;
      sign_r    <= 1'b0;
      eff_sub_r <= 1'b0;
    end else if (state_r == ALIGN) begin
      exp_r     <= cmp_exp_r;
      big_r     <= cmp_big_r;
      small_r   <= shifted_s;
      sign_r    <= cmp_sign_r;
      eff_sub_r <= cmp_eff_sub_r;
    end else begin
      eff_sub_r <= eff_sub_r;
    end
  end

`ifdef FP32_ALIGN_STICKY_EN
  logic [MANT_W-1:0] lost_mask_s;
  logic              sticky_s, sticky_r;

  // Sticky covers exactly the bits pushed below the LSB by the shift.
  always_comb begin
    lost_mask_s = (24'd1 << diff_r[4:0]) - 24'd1;
    sticky_s    = 1'b0;
    if (diff_r >= 8'd24) begin
      sticky_s = |cmp_small_r;
    end else begin
      sticky_s = |(cmp_small_r & lost_mask_s);
    end
  end

  // Sticky register shares the result-register timing.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sticky_r <= 1'b0;
    end else if (state_r == ALIGN) begin
      sticky_r <= sticky_s;
    end else begin
      sticky_r <= sticky_r;
    end
  end

  assign bus.o_sticky = sticky_r;
`else
  assign bus.o_sticky = 1'b0;
`endif

  assign bus.o_ready      = ready_r;
  assign bus.o_valid      = valid_r;
  assign bus.o_exp        = exp_r;
  assign bus.o_big_mant   = big_r;
  assign bus.o_small_mant = small_r;
  assign bus.o_sign       = sign_r;
  assign bus.o_eff_sub    = eff_sub_r;

endmodule

// File: tb/tb_fp32_align_ctrl.sv
// Self-checking bench for fp32_align_ctrl: directed cases, random operands
// against an arithmetic reference model, backpressure, reset and streaming.
module tb_fp32_align_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   fails = 0;

  fp32_align_ctrl_if bus ();

  fp32_align_ctrl dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

`ifdef FP32_ALIGN_STICKY_EN
  localparam logic STICKY_ON = 1'b1;
`else
  localparam logic STICKY_ON = 1'b0;
`endif

  // Result layout: {exp[7:0], big[23:0], small[23:0], sign, eff_sub, sticky}
  logic [58:0] got;
  int          lat;
  logic        timed_out;
  logic        post_valid, post_ready;

  // Reference: real-number style ordering by magnitude = eexp*2^24 + mant.
  function automatic logic [58:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic s);
    longint ea, eb, ma, mb, be, se, bm, sm, diff, al, p;
    logic   sw, st;
    ea = (a[30:23] == 8'd0) ? 1 : longint'(a[30:23]);
    eb = (b[30:23] == 8'd0) ? 1 : longint'(b[30:23]);
    ma = longint'(a[22:0]) + ((a[30:23] != 8'd0) ? 64'd8388608 : 64'd0);
    mb = longint'(b[22:0]) + ((b[30:23] != 8'd0) ? 64'd8388608 : 64'd0);
    sw = (eb * 16777216 + mb) > (ea * 16777216 + ma);
    be = sw ? eb : ea;  se = sw ? ea : eb;
    bm = sw ? mb : ma;  sm = sw ? ma : mb;
    diff = be - se;
    if (diff >= 24) begin
      al = 0;
      st = (sm != 0);
    end else begin
      p  = longint'(1) << diff;
      al = sm / p;
      st = (sm % p) != 0;
    end
    if (!STICKY_ON) st = 1'b0;
    return {be[7:0], bm[23:0], al[23:0], (sw ? (b[31] ^ s) : a[31]),
            a[31] ^ b[31] ^ s, st};
  endfunction

  function automatic logic [58:0] outs();
    return {bus.o_exp, bus.o_big_mant, bus.o_small_mant, bus.o_sign,
            bus.o_eff_sub, bus.o_sticky};
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int stall);
    @(negedge clk);
    bus.i_op_a = a; bus.i_op_b = b; bus.i_sub = s;
    bus.i_valid = 1'b1; bus.i_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.i_valid = 1'b0;
    lat = 1; timed_out = 1'b0;
    while (!bus.o_valid && !timed_out) begin
      @(negedge clk);
      lat++;
      if (lat > 20) timed_out = 1'b1;
    end
    got = outs();
    repeat (stall) @(negedge clk);
    bus.i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_ready = 1'b0;
    post_valid = bus.o_valid;
    post_ready = bus.o_ready;
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.o_ready, bus.o_valid, outs()} !== {1'b1, 1'b0, 59'd0}) begin
      fails++;
      $display("FAIL reset_values: got ready=%b valid=%b outs=%h, want ready=1 valid=0 outs=0",
               bus.o_ready, bus.o_valid, outs());
    end
  endtask

  task automatic test_directed();
    logic [31:0] va [4] = '{32'h3F800000, 32'h40400000, 32'h4B800000, 32'h00000001};
    logic [31:0] vb [4] = '{32'h40000000, 32'h3F800000, 32'h3F800001, 32'h00800000};
    logic        vs [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [58:0] ve [4];
    ve[0] = {8'h80, 24'h800000, 24'h400000, 1'b0, 1'b0, 1'b0};
    ve[1] = {8'h80, 24'hC00000, 24'h400000, 1'b0, 1'b1, 1'b0};
    ve[2] = {8'h97, 24'h800000, 24'h000000, 1'b0, 1'b0, STICKY_ON};
    ve[3] = {8'h01, 24'h800000, 24'h000001, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], vs[i], 1);
      checks++;
      if (lat !== 3 || timed_out) begin
        fails++;
        $display("FAIL directed%0d_latency: got %0d cycles, want 3", i, lat);
      end
      checks++;
      if (got !== ve[i]) begin
        fails++;
        $display("FAIL directed%0d_result: got %h, want %h", i, got, ve[i]);
      end
      checks++;
      if ({post_valid, post_ready} !== 2'b01) begin
        fails++;
        $display("FAIL directed%0d_handshake: got valid=%b ready=%b, want 0 1",
                 i, post_valid, post_ready);
      end
    end
  endtask

  task automatic test_random(input int n);
    logic [31:0] a, b;
    logic        s;
    logic [58:0] exp_v;
    for (int i = 0; i < n; i++) begin
      a = $urandom;
      b = $urandom;
      s = 1'($urandom_range(1, 0));
      case ($urandom_range(3, 0))
        0: b[30:23] = a[30:23] + 8'($urandom_range(30, 0));
        1: b[30:23] = a[30:23] - 8'($urandom_range(30, 0));
        2: begin a[30:23] = 8'($urandom_range(1, 0)); b[30:23] = 8'($urandom_range(2, 0)); end
        default: b = b;
      endcase
      exp_v = model(a, b, s);
      run_op(a, b, s, $urandom_range(2, 0));
      checks++;
      if (got !== exp_v || timed_out) begin
        fails++;
        $display("FAIL random%0d a=%h b=%h sub=%b: got %h, want %h", i, a, b, s, got, exp_v);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [58:0] hold_v, exp_v;
    int          wait_n;
    @(negedge clk);
    bus.i_op_a = 32'hC1200000; bus.i_op_b = 32'h3E800003; bus.i_sub = 1'b0;
    bus.i_valid = 1'b1; bus.i_ready = 1'b0;
    exp_v = model(32'hC1200000, 32'h3E800003, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus.i_valid = 1'b0;
    wait_n = 0;
    while (!bus.o_valid && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    hold_v = outs();
    checks++;
    if (hold_v !== exp_v || !bus.o_valid) begin
      fails++;
      $display("FAIL bp_result: got %h valid=%b, want %h valid=1", hold_v, bus.o_valid, exp_v);
    end
    for (int i = 0; i < 5; i++) begin
      bus.i_valid = (i % 2 == 0);
      bus.i_op_a = $urandom; bus.i_op_b = $urandom; bus.i_sub = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.o_valid, bus.o_ready, outs()} !== {1'b1, 1'b0, hold_v}) begin
        fails++;
        $display("FAIL bp_hold%0d: got valid=%b ready=%b outs=%h, want 1 0 %h",
                 i, bus.o_valid, bus.o_ready, outs(), hold_v);
      end
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_ready = 1'b0;
    checks++;
    if ({bus.o_valid, bus.o_ready} !== 2'b01) begin
      fails++;
      $display("FAIL bp_release: got valid=%b ready=%b, want 0 1", bus.o_valid, bus.o_ready);
    end
    @(negedge clk);
    checks++;
    if ({bus.o_valid, bus.o_ready} !== 2'b01) begin
      fails++;
      $display("FAIL bp_ignored: got valid=%b ready=%b, want 0 1", bus.o_valid, bus.o_ready);
    end
    exp_v = model(32'h42F60000, 32'hC2F60000, 1'b1);
    run_op(32'h42F60000, 32'hC2F60000, 1'b1, 0);
    checks++;
    if (got !== exp_v || lat !== 3) begin
      fails++;
      $display("FAIL bp_next_op: got %h lat=%0d, want %h lat=3", got, lat, exp_v);
    end
  endtask

  task automatic test_reset_in_align();
    logic [58:0] exp_v;
    run_op(32'h40490FDB, 32'h3FC00000, 1'b0, 0);
    @(negedge clk);
    bus.i_op_a = 32'h41000000; bus.i_op_b = 32'h40800001; bus.i_sub = 1'b1;
    bus.i_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.o_ready, bus.o_valid, outs()} !== {1'b1, 1'b0, 59'd0}) begin
      fails++;
      $display("FAIL reset_in_align: got ready=%b valid=%b outs=%h, want 1 0 0",
               bus.o_ready, bus.o_valid, outs());
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_v = model(32'h80000000, 32'h00000000, 1'b1);
    run_op(32'h80000000, 32'h00000000, 1'b1, 0);
    checks++;
    if (got !== exp_v || lat !== 3) begin
      fails++;
      $display("FAIL after_reset_op: got %h lat=%0d, want %h lat=3", got, lat, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    logic [58:0] q [$];
    logic [58:0] exp_v;
    int          done = 0;
    int          guard = 0;
    bus.i_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.o_valid) begin
        checks++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL b2b_extra: got unexpected result %h, want none", outs());
        end else begin
          exp_v = q.pop_front();
          done++;
          if (outs() !== exp_v) begin
            fails++;
            $display("FAIL b2b_result%0d: got %h, want %h", done, outs(), exp_v);
          end
        end
      end
      if (bus.o_ready) begin
        bus.i_op_a = $urandom; bus.i_op_b = $urandom;
        bus.i_sub = 1'($urandom_range(1, 0));
        bus.i_valid = 1'b1;
        q.push_back(model(bus.i_op_a, bus.i_op_b, bus.i_sub));
      end
    end
    bus.i_valid = 1'b0;
    checks++;
    if (done !== 10) begin
      fails++;
      $display("FAIL b2b_throughput: got %0d results in 40 cycles, want 10", done);
    end
    while (!bus.o_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    bus.i_ready = 1'b0;
  endtask

  initial begin
    bus.i_valid = 1'b0; bus.i_ready = 1'b0; bus.i_sub = 1'b0;
    bus.i_op_a = 32'd0; bus.i_op_b = 32'd0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_directed();
    test_random(120);
    test_backpressure();
    test_reset_in_align();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
